// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with arbitrary depth, level counter, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module ring_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int CW        = $clog2(FIFO_DEPTH + 1),
  localparam int PW        = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_val,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C      = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C      = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C     = CW'(1'b1);
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_val_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  not_full_s;
  logic                  not_empty_s;

  // Wrap explicitly at FIFO_DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // Status decode and accept qualification from the registered count only.
  always_comb begin
    not_full_s  = (count_r != DEPTH_C);
    not_empty_s = (count_r != ZERO_C);
    wr_acc_s    = wr_en & not_full_s;
    rd_acc_s    = rd_en & not_empty_s;
  end

  // Storage array; deliberately left without reset.
  always_ff @(posedge clk) begin
    if (reset_n && !flush && wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, read register and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= ZERO_C;
      rd_data_r   <= {DATA_WIDTH{1'b0}};
      rd_val_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      // rd_data is intentionally held across a flush.
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= ZERO_C;
      rd_val_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_acc_s) begin
        rd_ptr_r  <= ptr_inc(rd_ptr_r);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      rd_val_r <= rd_acc_s;
      if (wr_en && !not_full_s) begin
        overflow_r <= 1'b1;
      end
      if (rd_en && !not_empty_s) begin
        underflow_r <= 1'b1;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count        = count_r;
  assign wr_ready     = not_full_s;
  assign rd_ready     = not_empty_s;
  assign almost_full  = (count_r >= AF_C);
  assign almost_empty = (count_r <= AE_C);
  assign rd_data      = rd_data_r;
  assign rd_val       = rd_val_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule
